// File: rtl/multi_debounce_if.sv
// rtl/multi_debounce_if.sv - button pins and debounced event bundle shared by all consumers
interface multi_debounce_if #(
  parameter int CH = 4
);
  logic [CH-1:0] btn_in;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_press;
  logic [CH-1:0] btn_rel;
  logic [CH-1:0] btn_long;
  logic [CH-1:0] btn_rpt;

  // master: the debouncer; slave: the pin source / event consumers
  modport master (
    input  btn_in,
    output btn_level, btn_press, btn_rel, btn_long, btn_rpt
  );
  modport slave (
    output btn_in,
    input  btn_level, btn_press, btn_rel, btn_long, btn_rpt
  );
endinterface

// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - per-channel sync, stability filter, press/release/long/repeat events
// Optional auto-repeat (btn_rpt) is built only when MULTI_DEBOUNCE_REPEAT_EN is defined.
module multi_debounce #(
  parameter int CH         = 4,
  parameter int STABLE_CYC = 20000,
  parameter int LONG_CYC   = 1000000,
  parameter int REPEAT_CYC = 200000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_debounce_if.master     btn
);

  localparam int STB_W = $clog2(STABLE_CYC);
  localparam int HLD_W = $clog2(LONG_CYC + 1);
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYC - 1);
  localparam logic [HLD_W-1:0] HLD_MAX  = HLD_W'(LONG_CYC);
  localparam logic [HLD_W-1:0] HLD_PRE  = HLD_W'(LONG_CYC - 1);
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  localparam int RPC_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [RPC_W-1:0] RPC_LAST = RPC_W'(REPEAT_CYC - 1);
`endif

  logic [CH-1:0] level_v;
  logic [CH-1:0] press_v;
  logic [CH-1:0] rel_v;
  logic [CH-1:0] long_v;
  logic [CH-1:0] rpt_v;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             level;
    logic             press;
    logic             rel;
    logic             lng;
    logic [STB_W-1:0] stb;
    logic [HLD_W-1:0] hld;
    logic             norm;
    logic             accept;
    logic             rel_now;

    assign norm    = s2 ^ IDLE_PIN;
    assign accept  = (norm != level) && (stb == STB_LAST);
    assign rel_now = accept && !norm;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1    <= IDLE_PIN;
        s2    <= IDLE_PIN;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
        stb   <= '0;
        hld   <= '0;
      end else begin
        s1    <= btn.btn_in[i];
        s2    <= s1;
        press <= accept && norm;
        rel   <= rel_now;
        if (norm == level) begin
          stb <= '0;
        end else if (accept) begin
          level <= norm;
          stb   <= '0;
        end else begin
          stb <= stb + 1'b1;
        end
        if (!level) begin
          hld <= '0;
        end else if (hld != HLD_MAX) begin
          hld <= hld + 1'b1;
        end
        // a release accepted on the very edge the hold matures suppresses the long pulse
        lng <= level && (hld == HLD_PRE) && !rel_now;
      end
    end

`ifdef MULTI_DEBOUNCE_REPEAT_EN
    logic [RPC_W-1:0] rpc;
    logic             rpt;

    // repeat is armed once hld has saturated, i.e. from the edge after btn_long
    always_ff @(posedge clk) begin
      if (rst) begin
        rpc <= '0;
        rpt <= 1'b0;
      end else if (!level || (hld != HLD_MAX)) begin
        rpc <= '0;
        rpt <= 1'b0;
      end else if (rpc == RPC_LAST) begin
        rpc <= '0;
        rpt <= !rel_now;
      end else begin
        rpc <= rpc + 1'b1;
        rpt <= 1'b0;
      end
    end
    assign rpt_v[i] = rpt;
`else
    assign rpt_v[i] = 1'b0;
`endif

    assign level_v[i] = level;
    assign press_v[i] = press;
    assign rel_v[i]   = rel;
    assign long_v[i]  = lng;
  end

  assign btn.btn_level = level_v;
  assign btn.btn_press = press_v;
  assign btn.btn_rel   = rel_v;
  assign btn.btn_long  = long_v;
  assign btn.btn_rpt   = rpt_v;

endmodule
